// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and the pointer compare used for the full/empty flags.
package fifo_pkg;

  localparam int unsigned DSIZE_DEF = 8;
  localparam int unsigned ASIZE_DEF = 4;

  typedef struct packed {
    logic full;
    logic empty;
  } fifo_flags_t;

  // Pointers are passed zero-extended; only the low asize+1 bits take part.
  function automatic fifo_flags_t ptr_flags(input logic [31:0] wr_ptr,
                                            input logic [31:0] rd_ptr,
                                            input int unsigned asize);
    logic [31:0] mask;
    logic [31:0] diff;
    mask            = (32'd1 << (asize + 32'd1)) - 32'd1;
    diff            = (wr_ptr ^ rd_ptr) & mask;
    ptr_flags.empty = (diff == '0);
    ptr_flags.full  = (diff == (32'd1 << asize));
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: register array with a synchronous write port and an asynchronous read port.
module fifo_mem #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned ASIZE = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [ASIZE-1:0] waddr_i,
  input  logic [DSIZE-1:0] wdata_i,
  input  logic [ASIZE-1:0] raddr_i,
  output logic [DSIZE-1:0] rdata_o
);

  logic [DSIZE-1:0] mem_q [2**ASIZE];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock show-ahead FIFO: pointer registers, accept gating and full/empty flags.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE = DSIZE_DEF,
  parameter int unsigned ASIZE = ASIZE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] wr_data,
  input  logic             wr_inc,
  output logic             wr_full,
  input  logic             rd_inc,
  output logic             rd_empty,
  output logic [DSIZE-1:0] rd_data
);

  localparam logic [ASIZE:0] PTR_ONE = 1;

  logic [ASIZE:0]   wr_ptr_q, wr_ptr_d;
  logic [ASIZE:0]   rd_ptr_q, rd_ptr_d;
  logic             wr_en, rd_en;
  logic [DSIZE-1:0] mem_rdata;
  fifo_flags_t      flags;

  always_comb begin
    flags = ptr_flags(32'(wr_ptr_q), 32'(rd_ptr_q), ASIZE);
  end

  assign wr_full  = flags.full;
  assign rd_empty = flags.empty;
  assign wr_en    = wr_inc & ~flags.full;
  assign rd_en    = rd_inc & ~flags.empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  fifo_mem #(
    .DSIZE(DSIZE),
    .ASIZE(ASIZE)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[ASIZE-1:0]),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q[ASIZE-1:0]),
    .rdata_o (mem_rdata)
  );

  // Memory is not reset, so the head word is masked while empty.
  assign rd_data = flags.empty ? '0 : mem_rdata;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed and randomised checks of sync_fifo_ctrl against hand-computed values and a queue model.
module tb_sync_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] wr_data;
  logic       wr_inc;
  logic       rd_inc;
  logic       wr_full;
  logic       rd_empty;
  logic [7:0] rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(
    .DSIZE(8),
    .ASIZE(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_data  (wr_data),
    .wr_inc   (wr_inc),
    .wr_full  (wr_full),
    .rd_inc   (rd_inc),
    .rd_empty (rd_empty),
    .rd_data  (rd_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_inc  = 1'b0;
    rd_inc  = 1'b0;
    wr_data = 8'h00;
    rst_n   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (rd_empty !== 1'b1 || wr_full !== 1'b0 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_state got empty=%b full=%b data=%h want empty=1 full=0 data=00",
               rd_empty, wr_full, rd_data);
    end
    for (int i = 0; i < 3; i++) begin
      wr_inc  = 1'b1;
      wr_data = 8'hC0 + 8'(i);
      tick();
    end
    wr_inc = 1'b0;
    checks++;
    if (rd_empty !== 1'b0 || rd_data !== 8'hC0) begin
      errors++;
      $display("FAIL pre_reset_head got empty=%b data=%h want empty=0 data=c0", rd_empty, rd_data);
    end
    wr_inc  = 1'b1;
    wr_data = 8'hDD;
    rst_n   = 1'b0;
    #1;
    checks++;
    if (rd_empty !== 1'b1 || wr_full !== 1'b0 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got empty=%b full=%b data=%h want empty=1 full=0 data=00",
               rd_empty, wr_full, rd_data);
    end
    wr_inc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (rd_empty !== 1'b1 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL post_reset got empty=%b data=%h want empty=1 data=00", rd_empty, rd_data);
    end
  endtask

  task automatic test_empty_pop();
    do_reset();
    rd_inc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rd_empty !== 1'b1 || wr_full !== 1'b0 || rd_data !== 8'h00) begin
        errors++;
        $display("FAIL empty_pop cycle=%0d got empty=%b full=%b data=%h want empty=1 full=0 data=00",
                 i, rd_empty, wr_full, rd_data);
      end
    end
    rd_inc  = 1'b0;
    wr_inc  = 1'b1;
    wr_data = 8'h5A;
    tick();
    wr_inc = 1'b0;
    checks++;
    if (rd_empty !== 1'b0 || rd_data !== 8'h5A) begin
      errors++;
      $display("FAIL empty_pop_then_push got empty=%b data=%h want empty=0 data=5a", rd_empty, rd_data);
    end
    rd_inc = 1'b1;
    tick();
    rd_inc = 1'b0;
    checks++;
    if (rd_empty !== 1'b1 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL empty_pop_single got empty=%b data=%h want empty=1 data=00", rd_empty, rd_data);
    end
  endtask

  // Leaves the FIFO full with 0x00..0x0F for test_drain.
  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wr_inc  = 1'b1;
      wr_data = 8'(i);
      tick();
      checks++;
      if (wr_full !== (i == 15) || rd_empty !== 1'b0 || rd_data !== 8'h00) begin
        errors++;
        $display("FAIL fill push=%0d got full=%b empty=%b data=%h want full=%b empty=0 data=00",
                 i, wr_full, rd_empty, rd_data, (i == 15));
      end
    end
    wr_data = 8'hAA;
    tick();
    wr_inc = 1'b0;
    checks++;
    if (wr_full !== 1'b1 || rd_empty !== 1'b0 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL fill_overflow got full=%b empty=%b data=%h want full=1 empty=0 data=00",
               wr_full, rd_empty, rd_data);
    end
  endtask

  task automatic test_drain();
    rd_inc = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rd_data !== 8'(i) || rd_empty !== 1'b0) begin
        errors++;
        $display("FAIL drain pop=%0d got data=%h empty=%b want data=%h empty=0",
                 i, rd_data, rd_empty, 8'(i));
      end
      tick();
      checks++;
      if (wr_full !== 1'b0) begin
        errors++;
        $display("FAIL drain_full pop=%0d got full=%b want 0", i, wr_full);
      end
    end
    rd_inc = 1'b0;
    checks++;
    if (rd_empty !== 1'b1 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL drain_end got empty=%b data=%h want empty=1 data=00", rd_empty, rd_data);
    end
  endtask

  // Runs straight after the drain so the pointers start at 16 and wrap past 31.
  task automatic test_simultaneous();
    logic [7:0] exp;
    for (int i = 0; i < 5; i++) begin
      wr_inc  = 1'b1;
      wr_data = 8'h50 + 8'(i);
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      exp     = (k < 5) ? 8'h50 + 8'(k) : 8'h60 + 8'(k - 5);
      wr_inc  = 1'b1;
      rd_inc  = 1'b1;
      wr_data = 8'h60 + 8'(k);
      checks++;
      if (rd_data !== exp) begin
        errors++;
        $display("FAIL simul_head cycle=%0d got %h want %h", k, rd_data, exp);
      end
      tick();
      checks++;
      if (rd_empty !== 1'b0 || wr_full !== 1'b0) begin
        errors++;
        $display("FAIL simul_flags cycle=%0d got empty=%b full=%b want empty=0 full=0",
                 k, rd_empty, wr_full);
      end
    end
    wr_inc = 1'b0;
    rd_inc = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp = 8'h6F + 8'(k);
      checks++;
      if (rd_data !== exp || rd_empty !== 1'b0) begin
        errors++;
        $display("FAIL simul_tail pop=%0d got data=%h empty=%b want data=%h empty=0",
                 k, rd_data, rd_empty, exp);
      end
      tick();
    end
    rd_inc = 1'b0;
    checks++;
    if (rd_empty !== 1'b1) begin
      errors++;
      $display("FAIL simul_end got empty=%b want 1", rd_empty);
    end
  endtask

  task automatic test_full_simultaneous();
    do_reset();
    wr_inc = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'h20 + 8'(i);
      tick();
    end
    rd_inc  = 1'b1;
    wr_data = 8'hEE;
    tick();
    wr_inc = 1'b0;
    rd_inc = 1'b0;
    checks++;
    if (wr_full !== 1'b0 || rd_data !== 8'h21) begin
      errors++;
      $display("FAIL full_push_pop got full=%b data=%h want full=0 data=21", wr_full, rd_data);
    end
  endtask

  task automatic test_random();
    logic [7:0] model_q[$];
    logic [7:0] exp_data;
    int         pw;
    bit         wacc, racc;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      pw      = ((c / 150) % 2 == 0) ? 75 : 25;
      wr_inc  = ($urandom_range(0, 99) < pw);
      rd_inc  = ($urandom_range(0, 99) < (100 - pw));
      wr_data = 8'($urandom);
      wacc    = wr_inc && (model_q.size() < 16);
      racc    = rd_inc && (model_q.size() > 0);
      tick();
      if (racc) void'(model_q.pop_front());
      if (wacc) model_q.push_back(wr_data);
      exp_data = (model_q.size() > 0) ? model_q[0] : 8'h00;
      checks++;
      if (rd_data !== exp_data || wr_full !== (model_q.size() == 16) ||
          rd_empty !== (model_q.size() == 0)) begin
        errors++;
        $display("FAIL random cycle=%0d got data=%h full=%b empty=%b want data=%h full=%b empty=%b",
                 c, rd_data, wr_full, rd_empty, exp_data,
                 (model_q.size() == 16), (model_q.size() == 0));
      end
    end
    wr_inc = 1'b0;
    rd_inc = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    wr_inc  = 1'b0;
    rd_inc  = 1'b0;
    wr_data = 8'h00;
    tick();
    test_reset();
    test_empty_pop();
    test_fill();
    test_drain();
    test_simultaneous();
    test_full_simultaneous();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
